// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with a show-ahead byte FIFO and sticky error flags.
// Optional parity stage: define UART_RX_PARITY_EN (PARITY_ODD selects odd/even).
module uart_rx_fifo #(
    parameter int BAUD_MULT  = 1666,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                          i_uart_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rx_data,
    input  logic                          i_rx_ready,
    input  logic                          i_clear_err,
    output logic [7:0]                    o_byte_out,
    output logic                          o_data_valid,
    output logic                          o_rx_active,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_frame_err,
    output logic                          o_parity_err,
    output logic                          o_overrun
);

    localparam int CNT_W = $clog2(BAUD_MULT + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_MULT / 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_MULT);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    if (BAUD_MULT < 4 || DATA_BITS < 5 || DATA_BITS > 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_fifo: illegal parameter value");
    end

    // state  | meaning
    // IDLE   | line idle, waiting for a synchronized falling edge
    // START  | half-bit wait, then confirm the start bit is still low
    // DATA   | sampling DATA_BITS data bits, LSB first
    // PARITY | sampling the parity bit
    // STOP   | sampling the stop bit, then push / flag error
    // RESYNC | after a framing error, wait for the line to return high
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        RESYNC
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_rx_prev;
    logic                  w_rx;
    logic                  w_fall;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_tc;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  w_in_frame;
    logic                  w_par_ok;
    logic                  w_start_frame;
    logic                  w_sample_data;
    logic                  w_push_req;
    logic                  w_frame_evt;
    logic                  w_par_evt;

    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ovr_evt;
    logic                  r_frame_err;
    logic                  r_overrun;

    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= i_rx_data;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx       = r_sync2;
    assign w_fall     = r_rx_prev & ~r_sync2;
    assign w_tc       = (r_cnt == CNT_W'(1));
    assign w_in_frame = (r_state != IDLE) && (r_state != RESYNC);

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic w_sample_par;

    assign w_par_ok = (((^r_shift) ^ r_par_bit) == (PARITY_ODD != 0));

    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_par_bit <= 1'b0;
        end else if (w_sample_par) begin
            r_par_bit <= w_rx;
        end
    end
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_frame = 1'b0;
        w_sample_data = 1'b0;
        w_push_req    = 1'b0;
        w_frame_evt   = 1'b0;
        w_par_evt     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_sample_par  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt   = START;
                    w_start_frame = 1'b1;
                end
            end
            START: begin
                // a start bit that is high again at mid-bit was only a glitch
                if (w_tc) begin
                    w_state_nxt = w_rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tc) begin
                    w_sample_data = 1'b1;
                    if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_tc) begin
                    w_sample_par = 1'b1;
                    w_state_nxt  = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tc) begin
                    if (!w_rx) begin
                        w_frame_evt = 1'b1;
                        w_state_nxt = RESYNC;
                    end else if (!w_par_ok) begin
                        w_par_evt   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_push_req  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            RESYNC: begin
                if (w_rx) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_start_frame) begin
            r_cnt <= CNT_HALF;
        end else if (w_in_frame) begin
            r_cnt <= w_tc ? CNT_FULL : (r_cnt - CNT_W'(1));
        end
    end

    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_start_frame) begin
            r_bit_cnt <= '0;
        end else if (w_sample_data) begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
        end
    end

    assign w_full    = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_pop     = o_data_valid && i_rx_ready;
    // a simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_ovr_evt = w_push_req && w_full && !w_pop;

    always_ff @(posedge i_uart_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PTR_W + 1)'(1);
            end
        end
    end

    // error events take priority over a clear in the same cycle
    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= (r_frame_err && !i_clear_err) || w_frame_evt;
            r_overrun   <= (r_overrun && !i_clear_err) || w_ovr_evt;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= (r_parity_err && !i_clear_err) || w_par_evt;
        end
    end

    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_data_valid = (r_count != '0);
    assign o_byte_out   = o_data_valid ? 8'(r_mem[r_rd_ptr]) : 8'h00;
    assign o_fifo_count = r_count;
    assign o_rx_active  = w_in_frame;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: line-level receiver model with a byte queue, compared every cycle.
module tb_uart_rx_fifo;
    localparam int BAUD  = 4;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int PODD  = 0;
    localparam int H     = BAUD / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NP = 1;
`else
    localparam int NP = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic ready = 1'b0;
    logic clr   = 1'b0;
    logic [7:0] byte_out;
    logic valid;
    logic active;
    logic [$clog2(DEPTH):0] count;
    logic ferr;
    logic perr;
    logic ovr;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .BAUD_MULT (BAUD),
        .DATA_BITS (DB),
        .FIFO_DEPTH(DEPTH),
        .PARITY_ODD(PODD)
    ) dut (
        .i_uart_clk  (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx),
        .i_rx_ready  (ready),
        .i_clear_err (clr),
        .o_byte_out  (byte_out),
        .o_data_valid(valid),
        .o_rx_active (active),
        .o_fifo_count(count),
        .o_frame_err (ferr),
        .o_parity_err(perr),
        .o_overrun   (ovr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: line seen through two sync stages; bit k of a frame is read
    // H + k*BAUD cycles after the cycle that first shows the falling edge.
    logic h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;
    int m_phase = 0;   // 0 idle, 1 in frame, 2 waiting for line high
    int m_t = 0;
    logic [7:0] m_bits = 8'h00;
    logic m_pbit = 1'b0;
    logic [7:0] m_q[$];
    logic m_ferr = 1'b0, m_perr = 1'b0, m_ovr = 1'b0;

    always @(posedge clk) begin : model
        logic s_cur;
        logic s_prev;
        logic pop;
        logic push_req;
        int j;
        if (!rst_n) begin
            m_phase = 0; m_t = 0;
            m_q.delete();
            m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
            h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
        end else begin
            s_cur    = h2;
            s_prev   = h3;
            pop      = (m_q.size() > 0) && ready;
            push_req = 1'b0;
            if (clr) begin
                m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
            end
            case (m_phase)
                0: if (s_prev && !s_cur) begin m_phase = 1; m_t = 0; end
                1: begin
                    m_t++;
                    if (m_t >= H && ((m_t - H) % BAUD) == 0) begin
                        j = (m_t - H) / BAUD;
                        if (j == 0) begin
                            if (s_cur) m_phase = 0;
                        end else if (j <= DB) begin
                            m_bits[j-1] = s_cur;
                        end else if (j <= DB + NP) begin
                            m_pbit = s_cur;
                        end else if (!s_cur) begin
                            m_ferr = 1'b1; m_phase = 2;
                        end else if (NP == 1 && (((^m_bits) ^ m_pbit) != (PODD != 0))) begin
                            m_perr = 1'b1; m_phase = 0;
                        end else begin
                            push_req = 1'b1; m_phase = 0;
                        end
                    end
                end
                default: if (s_cur) m_phase = 0;
            endcase
            if (pop) void'(m_q.pop_front());
            if (push_req) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_bits);
                else m_ovr = 1'b1;
            end
            h3 = h2; h2 = h1; h1 = rx;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", valid, 0);
            check("rst_count", count, 0);
            check("rst_byte", byte_out, 0);
            check("rst_active", active, 0);
            check("rst_errs", {ferr, perr, ovr}, 0);
        end else begin
            check("valid", valid, m_q.size() > 0);
            check("count", count, m_q.size());
            if (m_q.size() > 0) check("byte_out", byte_out, m_q[0]);
            check("rx_active", active, m_phase == 1);
            check("frame_err", ferr, m_ferr);
            check("parity_err", perr, m_perr);
            check("overrun", ovr, m_ovr);
        end
    end

    // Sole driver of ready/clr; rdy_div==0 holds rdy_hold, else ready with prob 1/rdy_div.
    int rdy_div = 0;
    logic rdy_hold = 1'b0;
    int clr_div = 0;
    int clr_req = 0;
    int clr_done = 0;

    initial forever begin
        @(posedge clk); #1;
        ready = (rdy_div == 0) ? rdy_hold : ($urandom_range(rdy_div - 1) == 0);
        if (clr_req != clr_done) begin
            clr = 1'b1;
            clr_done++;
        end else begin
            clr = (clr_div != 0) && ($urandom_range(clr_div - 1) == 0);
        end
    end

    task automatic put(input logic v, input int n);
        rx = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic idle(input int n);
        put(1'b1, n);
    endtask

    task automatic send(input logic [7:0] d, input logic stop_v, input logic flip);
        put(1'b0, BAUD);
        for (int i = 0; i < DB; i++) put(d[i], BAUD);
`ifdef UART_RX_PARITY_EN
        put((^d) ^ (PODD != 0) ^ flip, BAUD);
`endif
        put(stop_v, BAUD);
    endtask

    logic [7:0] cap[$];

    task automatic capture(input int n);
        repeat (n) begin
            @(negedge clk);
            if (valid && ready) cap.push_back(byte_out);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        idle(6);

        // single byte 0x41
        send(8'h41, 1'b1, 1'b0);
        idle(4);
        @(negedge clk);
        check("t41_valid", valid, 1);
        check("t41_byte", byte_out, 8'h41);
        check("t41_count", count, 1);
        @(posedge clk); #1;
        rdy_hold = 1'b1; idle(4); rdy_hold = 1'b0; idle(2);
        @(negedge clk);
        check("t41_drained", count, 0);
        @(posedge clk); #1;

        // one-cycle glitch
        put(1'b0, 1);
        idle(12);
        @(negedge clk);
        check("glitch_valid", valid, 0);
        check("glitch_errs", {ferr, perr, ovr}, 0);
        check("glitch_active", active, 0);
        @(posedge clk); #1;

        // overrun: five bytes into a depth-4 FIFO
        for (int v = 1; v <= 5; v++) send(8'(v), 1'b1, 1'b0);
        idle(4);
        @(negedge clk);
        check("ovr_count", count, 4);
        check("ovr_flag", ovr, 1);
        check("ovr_head", byte_out, 8'h01);
        @(posedge clk); #1;
        cap.delete();
        rdy_hold = 1'b1; capture(10); rdy_hold = 1'b0;
        check("ovr_popped_n", cap.size(), 4);
        for (int k = 0; k < 4; k++)
            check("ovr_pop_order", (k < cap.size()) ? int'(cap[k]) : -1, k + 1);
        clr_req++;
        idle(4);
        @(negedge clk);
        check("ovr_cleared", ovr, 0);
        @(posedge clk); #1;

        // framing error, then recovery
        send(8'h55, 1'b0, 1'b0);
        put(1'b0, 20);
        idle(6);
        @(negedge clk);
        check("fe_flag", ferr, 1);
        check("fe_no_push", valid, 0);
        @(posedge clk); #1;
        clr_req++;
        idle(4);
        send(8'hA5, 1'b1, 1'b0);
        idle(4);
        @(negedge clk);
        check("fe_cleared", ferr, 0);
        check("fe_next_byte", byte_out, 8'hA5);
        check("fe_next_count", count, 1);
        @(posedge clk); #1;
        rdy_hold = 1'b1; idle(4); rdy_hold = 1'b0;

`ifdef UART_RX_PARITY_EN
        send(8'h03, 1'b1, 1'b1);
        idle(4);
        @(negedge clk);
        check("par_flag", perr, 1);
        check("par_discard", valid, 0);
        @(posedge clk); #1;
        clr_req++;
        idle(3);
        send(8'h03, 1'b1, 1'b0);
        idle(4);
        @(negedge clk);
        check("par_ok_byte", byte_out, 8'h03);
        check("par_ok_flag", perr, 0);
        @(posedge clk); #1;
        rdy_hold = 1'b1; idle(4); rdy_hold = 1'b0;
`endif

        // reset in the middle of a 0xFF frame, with a byte already queued
        send(8'h3C, 1'b1, 1'b0);
        idle(4);
        put(1'b0, BAUD);
        put(1'b1, 3 * BAUD);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_count", count, 0);
        check("rst_mid_active", active, 0);
        @(posedge clk); #1;
        idle(3);
        rst_n = 1'b1;
        idle(8 * BAUD);
        @(negedge clk);
        check("rst_after_valid", valid, 0);
        check("rst_after_active", active, 0);
        check("rst_after_errs", {ferr, perr, ovr}, 0);
        @(posedge clk); #1;

        // randomized traffic
        clr_div = 80;
        for (int f = 0; f < 150; f++) begin
            if ((f % 25) == 0) rdy_div = $urandom_range(1, 12);
            r = $urandom_range(0, 19);
            if (r == 0) begin
                put(1'b0, $urandom_range(1, H));
                idle($urandom_range(H + 2, 10));
            end else begin
                send(8'($urandom_range(0, 255)), r != 1, r == 2);
                if (r == 1) put(1'b0, $urandom_range(0, 10));
                idle($urandom_range(1, 12));
            end
        end

        rdy_div = 0; rdy_hold = 1'b1; clr_div = 0;
        idle(40);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
